// File: rtl/spi_xfer_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module : spi_xfer_sequencer_pkg
// Brief  : Shared types and default sizes for the SPI transfer sequencer.
// Rev    : 1.0
// ============================================================================
package spi_xfer_sequencer_pkg;

  localparam int C_BITS  = 8;
  localparam int C_DIV_W = 8;
  localparam int C_GAP   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  // Edge counter must hold 0..2*BITS.
  function automatic int edge_cnt_width(input int bits);
    return $clog2(2 * bits + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_xfer_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : spi_xfer_sequencer_if
// Brief  : Register front-end handshake and SPI-side strobes of the sequencer.
// Rev    : 1.0
// ============================================================================
interface spi_xfer_sequencer_if
  import spi_xfer_sequencer_pkg::*;
#(
  parameter int DIV_W = C_DIV_W
);

  logic             start;
  logic             ready;
  logic             abort;
  logic             cpol;
  logic             cphase;
  logic [DIV_W-1:0] clk_div;
  logic             cphase_q;
  logic             cpol_q;
  logic             busy;
  logic             done;
  logic             ss;
  logic             sclk;
  logic             send_data;
  logic             receive_data;
  logic             flag_low;
  logic             flag_high;
  logic             flags_low;
  logic             flags_high;

  modport slave (
    input  start, abort, cpol, cphase, clk_div,
    output ready, cphase_q, cpol_q, busy, done, ss, sclk, send_data,
           receive_data, flag_low, flag_high, flags_low, flags_high
  );

  modport master (
    output start, abort, cpol, cphase, clk_div,
    input  ready, cphase_q, cpol_q, busy, done, ss, sclk, send_data,
           receive_data, flag_low, flag_high, flags_low, flags_high
  );

endinterface
`default_nettype wire

// File: rtl/spi_xfer_sequencer_baud_gen.sv
`default_nettype none
// ============================================================================
// Module : spi_baud_gen
// Brief  : SCLK divider, toggle and flag/flags look-ahead strobes for XFER.
// Rev    : 1.0
// ============================================================================
module spi_baud_gen
  import spi_xfer_sequencer_pkg::*;
#(
  parameter int DIV_W = C_DIV_W
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_en,
  input  wire logic             i_en_next,
  input  wire logic [DIV_W-1:0] i_div,
  input  wire logic             i_idle_lvl,
  output logic                  o_tick,
  output logic                  o_sclk,
  output logic                  o_flag_low,
  output logic                  o_flag_high,
  output logic                  o_flags_low,
  output logic                  o_flags_high
);

  localparam int CW = DIV_W + 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          flag_low_q, flag_low_d;
  logic          flag_high_q, flag_high_d;
  logic          flags_low_q, flags_low_d;
  logic          flags_high_q, flags_high_d;
  logic [CW-1:0] w_hm1;
  logic [CW-1:0] w_hm2;
  logic          w_tick;

  // Half-period H = div + 2, so the terminal count H-1 is div + 1.
  assign w_hm1  = {1'b0, i_div} + CW'(1);
  assign w_hm2  = {1'b0, i_div};
  assign w_tick = i_en && (cnt_q == w_hm1);

  // Strobes are registered, so they are decoded from next-cycle count and level.
  always_comb begin
    cnt_d        = '0;
    sclk_d       = i_idle_lvl;
    flag_low_d   = 1'b0;
    flag_high_d  = 1'b0;
    flags_low_d  = 1'b0;
    flags_high_d = 1'b0;
    if (i_en_next) begin
      if (i_en && !w_tick) begin
        cnt_d = cnt_q + CW'(1);
      end
      sclk_d       = w_tick ? ~sclk_q : sclk_q;
      flag_low_d   = (cnt_d == w_hm1) && !sclk_d;
      flag_high_d  = (cnt_d == w_hm1) &&  sclk_d;
      flags_low_d  = (cnt_d == w_hm2) && !sclk_d;
      flags_high_d = (cnt_d == w_hm2) &&  sclk_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      sclk_q       <= 1'b0;
      flag_low_q   <= 1'b0;
      flag_high_q  <= 1'b0;
      flags_low_q  <= 1'b0;
      flags_high_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      sclk_q       <= sclk_d;
      flag_low_q   <= flag_low_d;
      flag_high_q  <= flag_high_d;
      flags_low_q  <= flags_low_d;
      flags_high_q <= flags_high_d;
    end
  end

  assign o_tick       = w_tick;
  assign o_sclk       = sclk_q;
  assign o_flag_low   = flag_low_q;
  assign o_flag_high  = flag_high_q;
  assign o_flags_low  = flags_low_q;
  assign o_flags_high = flags_high_q;

endmodule
`default_nettype wire

// File: rtl/spi_xfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module : spi_xfer_sequencer
// Brief  : SPI master transfer sequencer: ss, SCLK, load/receive windows, done.
// Rev    : 1.0
// ============================================================================
module spi_xfer_sequencer
  import spi_xfer_sequencer_pkg::*;
#(
  parameter int BITS  = C_BITS,
  parameter int DIV_W = C_DIV_W,
  parameter int GAP   = C_GAP
) (
  input  wire logic           PCLK,
  input  wire logic           PRESET,
  spi_xfer_sequencer_if.slave bus
);

  localparam int EW = edge_cnt_width(BITS);
  localparam int GW = $clog2(GAP + 1);
  localparam int CW = DIV_W + 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    tmr_q, tmr_d;
  logic [EW-1:0]    edges_q, edges_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             cpol_lat_q, cpol_lat_d;
  logic             cpha_lat_q, cpha_lat_d;
  logic             ss_q, ss_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             send_q, send_d;
  logic             recv_q, recv_d;
  logic             ready_q, ready_d;

  logic             w_accept;
  logic             w_last_tmr;
  logic             w_idle_lvl;
  logic             w_tick;
  logic [CW-1:0]    w_hm1;
  logic             w_sclk;
  logic             w_flag_low;
  logic             w_flag_high;
  logic             w_flags_low;
  logic             w_flags_high;

  assign w_hm1      = {1'b0, div_q} + CW'(1);
  assign w_accept   = (state_q == ST_IDLE) && bus.start && ready_q;
  assign w_last_tmr = (tmr_q == w_hm1);
  // The idle level follows the value being latched on the accept edge.
  assign w_idle_lvl = w_accept ? bus.cpol : cpol_lat_q;

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    edges_d    = edges_q;
    gap_d      = gap_q;
    div_d      = div_q;
    cpol_lat_d = cpol_lat_q;
    cpha_lat_d = cpha_lat_q;
    done_d     = 1'b0;
    send_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (gap_q != '0) begin
          gap_d = gap_q - GW'(1);
        end
        if (w_accept) begin
          state_d    = ST_SETUP;
          tmr_d      = '0;
          div_d      = bus.clk_div;
          cpol_lat_d = bus.cpol;
          cpha_lat_d = bus.cphase;
          send_d     = 1'b1;
        end
      end
      ST_SETUP: begin
        if (w_last_tmr) begin
          state_d = ST_XFER;
          tmr_d   = '0;
          edges_d = '0;
        end else begin
          tmr_d = tmr_q + CW'(1);
        end
      end
      ST_XFER: begin
        if (w_tick) begin
          edges_d = edges_q + EW'(1);
          if (edges_q == EW'(2 * BITS - 1)) begin
            state_d = ST_HOLD;
            tmr_d   = '0;
          end
        end
      end
      ST_HOLD: begin
        if (w_last_tmr) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          gap_d   = GW'(GAP);
        end else begin
          tmr_d = tmr_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort only matters once a transfer is in flight; a simultaneous start in IDLE wins.
    if (bus.abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      tmr_d   = '0;
      gap_d   = GW'(GAP);
      done_d  = 1'b0;
    end

    ss_d    = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
    recv_d  = (state_d == ST_XFER);
    ready_d = (state_d == ST_IDLE) && (gap_d == '0);
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q    <= ST_IDLE;
      tmr_q      <= '0;
      edges_q    <= '0;
      gap_q      <= GW'(GAP);
      div_q      <= '0;
      cpol_lat_q <= 1'b0;
      cpha_lat_q <= 1'b0;
      ss_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      send_q     <= 1'b0;
      recv_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      edges_q    <= edges_d;
      gap_q      <= gap_d;
      div_q      <= div_d;
      cpol_lat_q <= cpol_lat_d;
      cpha_lat_q <= cpha_lat_d;
      ss_q       <= ss_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      send_q     <= send_d;
      recv_q     <= recv_d;
      ready_q    <= ready_d;
    end
  end

  spi_baud_gen #(
    .DIV_W (DIV_W)
  ) u_baud_gen (
    .clk          (PCLK),
    .rst          (PRESET),
    .i_en         (state_q == ST_XFER),
    .i_en_next    (state_d == ST_XFER),
    .i_div        (div_q),
    .i_idle_lvl   (w_idle_lvl),
    .o_tick       (w_tick),
    .o_sclk       (w_sclk),
    .o_flag_low   (w_flag_low),
    .o_flag_high  (w_flag_high),
    .o_flags_low  (w_flags_low),
    .o_flags_high (w_flags_high)
  );

  assign bus.ready        = ready_q;
  assign bus.cphase_q     = cpha_lat_q;
  assign bus.cpol_q       = cpol_lat_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.ss           = ss_q;
  assign bus.sclk         = w_sclk;
  assign bus.send_data    = send_q;
  assign bus.receive_data = recv_q;
  assign bus.flag_low     = w_flag_low;
  assign bus.flag_high    = w_flag_high;
  assign bus.flags_low    = w_flags_low;
  assign bus.flags_high   = w_flags_high;

endmodule
`default_nettype wire

// File: tb/tb_spi_xfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_spi_xfer_sequencer
// Brief  : Randomised scoreboard bench for spi_xfer_sequencer.
// Rev    : 1.0
// ============================================================================
module tb_spi_xfer_sequencer;
  import spi_xfer_sequencer_pkg::*;

  localparam int BITS  = 8;
  localparam int DIV_W = 8;
  localparam int GAP   = 2;
  localparam int N     = 2 * BITS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_xfer_sequencer_if #(.DIV_W(DIV_W)) bus ();

  spi_xfer_sequencer #(
    .BITS  (BITS),
    .DIV_W (DIV_W),
    .GAP   (GAP)
  ) dut (
    .PCLK   (clk),
    .PRESET (rst),
    .bus    (bus)
  );

  // One transfer, summarised as it is seen on the pins while ss is low.
  typedef struct {
    int ss_len;
    int n_tog;
    int tog_sum;
    int recv_cnt;
    int fl_lo_cnt;
    int fl_lo_sum;
    int fl_hi_cnt;
    int fl_hi_sum;
    int fs_lo_cnt;
    int fs_lo_sum;
    int fs_hi_cnt;
    int fs_hi_sum;
    int send_at0;
    int done;
    int end_sclk;
    int end_cpol;
    int cpol;
    int cpha;
    int sclk0;
  } rec_t;

  rec_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   stray  = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // kind: 0 = runs to completion, 1 = abort during offset a, 2 = reset during offset a.
  // Offsets count cycles from the first cycle with ss low.
  function automatic rec_t model(input int cpol, input int cpha, input int div,
                                 input int kind, input int a);
    rec_t r;
    int   h;
    int   last;
    int   rend;
    r = '{default: 0};
    h = div + 2;
    r.ss_len = (kind == 0) ? (N + 2) * h : a + 1;
    last = r.ss_len - 1;
    for (int j = 0; j < N; j++) begin
      int t;
      int lv;
      t  = (2 + j) * h;
      lv = cpol ^ (j % 2);
      if (t <= last) begin
        r.n_tog++;
        r.tog_sum += t;
      end
      if (t - 1 <= last) begin
        if (lv == 0) begin r.fl_lo_cnt++; r.fl_lo_sum += t - 1; end
        else         begin r.fl_hi_cnt++; r.fl_hi_sum += t - 1; end
      end
      if (t - 2 <= last) begin
        if (lv == 0) begin r.fs_lo_cnt++; r.fs_lo_sum += t - 2; end
        else         begin r.fs_hi_cnt++; r.fs_hi_sum += t - 2; end
      end
    end
    rend = ((N + 1) * h - 1 < last) ? (N + 1) * h - 1 : last;
    r.recv_cnt = (rend >= h) ? rend - h + 1 : 0;
    r.send_at0 = 1;
    r.done     = (kind == 0) ? 1 : 0;
    r.end_sclk = (kind == 2) ? 0 : cpol;
    r.end_cpol = (kind == 2) ? 0 : cpol;
    r.cpol     = cpol;
    r.cpha     = cpha;
    r.sclk0    = cpol;
    return r;
  endfunction

  function automatic rec_t acc(input rec_t r, input int o, input logic prev);
    if (o > 0 && bus.sclk !== prev) begin r.n_tog++; r.tog_sum += o; end
    if (bus.receive_data === 1'b1) r.recv_cnt++;
    if (bus.flag_low   === 1'b1) begin r.fl_lo_cnt++; r.fl_lo_sum += o; end
    if (bus.flag_high  === 1'b1) begin r.fl_hi_cnt++; r.fl_hi_sum += o; end
    if (bus.flags_low  === 1'b1) begin r.fs_lo_cnt++; r.fs_lo_sum += o; end
    if (bus.flags_high === 1'b1) begin r.fs_hi_cnt++; r.fs_hi_sum += o; end
    if (bus.send_data  === 1'b1) r.send_at0 += (o == 0) ? 1 : 100;
    return r;
  endfunction

  task automatic compare(input rec_t m, input rec_t e);
    chk("ss_low_len",     m.ss_len,    e.ss_len);
    chk("sclk_toggles",   m.n_tog,     e.n_tog);
    chk("sclk_toggle_at", m.tog_sum,   e.tog_sum);
    chk("receive_cycles", m.recv_cnt,  e.recv_cnt);
    chk("flag_low_cnt",   m.fl_lo_cnt, e.fl_lo_cnt);
    chk("flag_low_at",    m.fl_lo_sum, e.fl_lo_sum);
    chk("flag_high_cnt",  m.fl_hi_cnt, e.fl_hi_cnt);
    chk("flag_high_at",   m.fl_hi_sum, e.fl_hi_sum);
    chk("flags_low_cnt",  m.fs_lo_cnt, e.fs_lo_cnt);
    chk("flags_low_at",   m.fs_lo_sum, e.fs_lo_sum);
    chk("flags_high_cnt", m.fs_hi_cnt, e.fs_hi_cnt);
    chk("flags_high_at",  m.fs_hi_sum, e.fs_hi_sum);
    chk("send_data",      m.send_at0,  e.send_at0);
    chk("done_pulse",     m.done,      e.done);
    chk("sclk_at_end",    m.end_sclk,  e.end_sclk);
    chk("cpol_q_at_end",  m.end_cpol,  e.end_cpol);
    chk("cpol_q",         m.cpol,      e.cpol);
    chk("cphase_q",       m.cpha,      e.cpha);
    chk("sclk_idle",      m.sclk0,     e.sclk0);
  endtask

  function automatic logic any_strobe();
    return bus.flag_low === 1'b1 || bus.flag_high === 1'b1 ||
           bus.flags_low === 1'b1 || bus.flags_high === 1'b1;
  endfunction

  // Monitor: rebuilds each transfer from the pins and scores it on ss rise.
  initial begin : monitor
    rec_t m;
    rec_t e;
    int   off;
    int   hi_run;
    bit   in_x;
    bit   seen;
    logic prev_sclk;
    m = '{default: 0};
    off = 0; hi_run = 0; in_x = 0; seen = 0; prev_sclk = 1'b0;
    forever begin
      @(negedge clk);
      if (in_x && bus.ss === 1'b0) begin
        off++;
        m = acc(m, off, prev_sclk);
        prev_sclk = bus.sclk;
        if (bus.busy !== 1'b1 || bus.ready === 1'b1 || bus.done === 1'b1) stray++;
      end else if (in_x) begin
        in_x       = 0;
        m.ss_len   = off + 1;
        m.done     = int'(bus.done === 1'b1);
        m.end_sclk = int'(bus.sclk === 1'b1);
        m.end_cpol = int'(bus.cpol_q === 1'b1);
        if (bus.busy === 1'b1 || bus.receive_data === 1'b1 ||
            bus.send_data === 1'b1 || any_strobe()) stray++;
        if (exp_q.size() == 0) begin
          chk("unexpected_transfer", 1, 0);
        end else begin
          e = exp_q.pop_front();
          compare(m, e);
        end
        hi_run = 1;
      end else if (bus.ss === 1'b0) begin
        if (seen) chk("ss_high_gap_ge_GAP", int'(hi_run >= GAP), 1);
        seen    = 1;
        in_x    = 1;
        off     = 0;
        m       = '{default: 0};
        m.cpol  = int'(bus.cpol_q === 1'b1);
        m.cpha  = int'(bus.cphase_q === 1'b1);
        m.sclk0 = int'(bus.sclk === 1'b1);
        m = acc(m, 0, bus.sclk);
        prev_sclk = bus.sclk;
        if (bus.busy !== 1'b1 || bus.ready === 1'b1 || bus.done === 1'b1) stray++;
      end else begin
        hi_run++;
        if (bus.busy === 1'b1 || bus.receive_data === 1'b1 || bus.send_data === 1'b1 ||
            bus.done === 1'b1 || any_strobe()) stray++;
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ss"},        int'(bus.ss === 1'b1), 1);
    chk({tag, "_sclk"},      int'(bus.sclk),         0);
    chk({tag, "_cpol_q"},    int'(bus.cpol_q),       0);
    chk({tag, "_cphase_q"},  int'(bus.cphase_q),     0);
    chk({tag, "_busy"},      int'(bus.busy),         0);
    chk({tag, "_done"},      int'(bus.done),         0);
    chk({tag, "_send_data"}, int'(bus.send_data),    0);
    chk({tag, "_receive"},   int'(bus.receive_data), 0);
    chk({tag, "_flags"},     int'({bus.flag_low, bus.flag_high, bus.flags_low, bus.flags_high}), 0);
    chk({tag, "_ready"},     int'(bus.ready),        0);
  endtask

  task automatic xfer(input int cpol, input int cpha, input int div,
                      input int kind, input int a, input bit hold);
    int n;
    int h;
    int len;
    h = div + 2;
    bus.cpol    = cpol[0];
    bus.cphase  = cpha[0];
    bus.clk_div = DIV_W'(div);
    bus.start   = 1'b1;
    bus.abort   = 1'($urandom);
    n = 0;
    while (bus.ready !== 1'b1 && n < 64) begin
      @(posedge clk); #1;
      bus.abort = 1'($urandom);
      n++;
    end
    if (bus.ready !== 1'b1) begin
      chk("ready_timeout", 0, 1);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      return;
    end
    exp_q.push_back(model(cpol, cpha, div, kind, a));
    @(posedge clk); #1;
    bus.start = hold;
    bus.abort = 1'b0;
    len = (kind == 0) ? (N + 2) * h : a + 1;
    for (int o = 0; o < len; o++) begin
      bus.cpol    = 1'($urandom);
      bus.cphase  = 1'($urandom);
      bus.clk_div = DIV_W'($urandom);
      if (kind == 1 && o == a) bus.abort = 1'b1;
      if (kind == 2 && o == a) rst = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
      if (kind == 2 && o == a) begin
        check_reset_vals("preset_mid");
        rst = 1'b0;
      end
    end
    if (!hold) bus.start = 1'b0;
  endtask

  initial begin : stim
    int h;
    int r;
    int kind;
    bus.start = 1'b0; bus.abort = 1'b0; bus.cpol = 1'b0;
    bus.cphase = 1'b0; bus.clk_div = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;
    for (int i = 1; i <= GAP; i++) begin
      @(posedge clk); #1;
      chk("ready_after_reset", int'(bus.ready), (i == GAP) ? 1 : 0);
    end

    xfer(0, 0, 0,   0, 0, 1'b0);            // mode 0, H=2
    xfer(1, 0, 3,   0, 0, 1'b0);            // cpol=1, H=5
    xfer(0, 1, 2,   0, 0, 1'b1);            // start held, H=4
    xfer(0, 1, 2,   0, 0, 1'b1);
    xfer(1, 1, 2,   0, 0, 1'b0);
    xfer(0, 0, 2,   1, 8 * 4, 1'b0);        // abort on the 7th SCLK edge
    xfer(1, 0, 1,   2, 3 + 10, 1'b1);       // PRESET mid-XFER
    xfer(1, 1, 255, 0, 0, 1'b0);            // largest divider

    for (int i = 0; i < 20; i++) begin
      h = 0;
      r = int'($urandom_range(0, 9));
      kind = (r < 6) ? 0 : (r < 9) ? 1 : 2;
      h = int'($urandom_range(0, 5));
      xfer(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), h, kind,
           int'($urandom_range(0, (N + 2) * (h + 2) - 1)), 1'($urandom));
    end

    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("stray_outputs", stray, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
